mux_scan: RTL and testbench

Parametrised, registered N-channel multiplexer with an autonomous scan sequencer; the successor to the fixed 8:1 combinational mux. In manual mode it acts as a registered `CHANNELS:1` mux of `WIDTH`-bit lanes. In scan mode, a `start` pulse makes it step through every channel enabled in `en_mask`, dwelling `DWELL` cycles on each and strobing `valid` at the sample point. It feeds downstream samplers and loggers that consume one channel at a time.

---
 rtl/mux_scan_pkg.sv | 17 +
 rtl/mux_scan_next.sv | 28 ++
 rtl/mux_scan.sv | 151 +++++++++++++++
 tb/tb_mux_scan.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan block: FSM state encoding and
// the select-width helper used to size channel indices.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Width of a channel index. Equals $clog2(n) for any n >= 2; the floor of
  // 1 keeps degenerate sizes from producing a zero-width select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Combinational search for the lowest enabled channel strictly above `cur`.
// Passing cur = -1 yields the first enabled channel of the mask.
module mux_scan_next
  import mux_scan_pkg::*;
#(
  parameter  int CHANNELS = 8,
  localparam int SW       = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] en_mask,
  input  logic signed [SW:0]  cur,
  output logic [SW-1:0]       nxt,
  output logic                none
);

  // Walking down from the top leaves the lowest qualifying index in nxt.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (en_mask[k] && (k > int'(cur))) begin
        nxt  = SW'(k);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered CHANNELS:1 mux with a scan sequencer: manual select when mode=0,
// autonomous ascending walk over enabled channels when mode=1 and started.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 8,
  parameter  int DWELL    = 4,
  localparam int SW       = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic                      mode,
  input  logic [SW-1:0]             sel_in,
  input  logic [CHANNELS-1:0]       en_mask,
  input  logic                      start,
  output logic [WIDTH-1:0]          out,
  output logic [SW-1:0]             sel_out,
  output logic                      valid,
  output logic                      busy,
  output logic                      done
);

  localparam int            CW   = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  state_e         state_q, state_d;
  logic [SW-1:0]  cur_q, cur_d;
  logic [CW-1:0]  dwell_q, dwell_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SW-1:0]  sel_out_q, sel_out_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic signed [SW:0] search_from;
  logic [SW-1:0]      nxt_idx;
  logic               nxt_none;
  logic [WIDTH-1:0]   man_lane, cur_lane;
  logic               man_hit;

  // Outside SCAN the search starts from -1 so it returns the first channel.
  assign search_from = (state_q == SCAN) ? $signed({1'b0, cur_q}) : '1;

  mux_scan_next #(
    .CHANNELS (CHANNELS)
  ) u_next (
    .en_mask (en_mask),
    .cur     (search_from),
    .nxt     (nxt_idx),
    .none    (nxt_none)
  );

  // Loop-based lane select; an out-of-range manual select simply never hits.
  always_comb begin
    man_lane = '0;
    man_hit  = 1'b0;
    cur_lane = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_in == SW'(k)) begin
        man_lane = in[k*WIDTH +: WIDTH];
        man_hit  = 1'b1;
      end
      if (cur_q == SW'(k)) cur_lane = in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    dwell_d   = dwell_q;
    out_d     = out_q;
    sel_out_d = sel_out_q;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    if (!mode) begin
      // Manual mode, which also aborts any scan without a done pulse.
      state_d   = IDLE;
      dwell_d   = '0;
      out_d     = man_hit ? man_lane : '0;
      sel_out_d = sel_in;
      valid_d   = man_hit;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dwell_d = '0;
            if (nxt_none) begin
              state_d = FINISH;
            end else begin
              state_d = SCAN;
              cur_d   = nxt_idx;
            end
          end
        end
        SCAN: begin
          busy_d    = 1'b1;
          out_d     = cur_lane;
          sel_out_d = cur_q;
          valid_d   = (dwell_q == LAST);
          if (dwell_q == LAST) begin
            dwell_d = '0;
            if (nxt_none) state_d = FINISH;
            else          cur_d   = nxt_idx;
          end else begin
            dwell_d = dwell_q + CW'(1);
          end
        end
        FINISH: begin
          busy_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments; the reset is synchronous, so it
  // sits inside the clocked branch and wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      dwell_q   <= '0;
      out_q     <= '0;
      sel_out_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      dwell_q   <= dwell_d;
      out_q     <= out_d;
      sel_out_q <= sel_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out     = out_q;
  assign sel_out = sel_out_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: an 8x1 instance for manual and scan behaviour
// and a 5x8 instance for non-power-of-two, wide-lane manual selection.
module tb_mux_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8 channels x 1 bit, DWELL 4
  logic [7:0] in8, mask8;
  logic       mode8, start8;
  logic [2:0] sel8, sel_out8;
  logic [0:0] out8;
  logic       valid8, busy8, done8;

  // 5 channels x 8 bits
  logic [39:0] in5;
  logic [4:0]  mask5;
  logic        mode5, start5;
  logic [2:0]  sel5, sel_out5;
  logic [7:0]  out5;
  logic        valid5, busy5, done5;

  mux_scan #(.WIDTH(1), .CHANNELS(8), .DWELL(4)) u_dut8 (
    .clk(clk), .rst(rst), .in(in8), .mode(mode8), .sel_in(sel8),
    .en_mask(mask8), .start(start8), .out(out8), .sel_out(sel_out8),
    .valid(valid8), .busy(busy8), .done(done8)
  );

  mux_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(4)) u_dut5 (
    .clk(clk), .rst(rst), .in(in5), .mode(mode5), .sel_in(sel5),
    .en_mask(mask5), .start(start5), .out(out5), .sel_out(sel_out5),
    .valid(valid5), .busy(busy5), .done(done5)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         use5;
    logic [2:0] sel;
    logic [7:0] exp_out;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[15];

  // Pulses start, then watches strobes, the sel_out walk and the done pulse.
  task automatic run_scan(input string tag, input logic [7:0] mask, input int restart_at);
    int chans[$];
    int e;
    int done_at;
    int nstrobe;
    int bad_strobe;
    int bad_walk;
    done_at = -1;
    nstrobe = 0;
    bad_strobe = 0;
    bad_walk = 0;
    for (int k = 0; k < 8; k++) if (mask[k]) chans.push_back(k);
    e = chans.size();
    mode8 = 1'b1;
    mask8 = mask;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int n = 1; n <= 60 && done_at < 0; n++) begin
      if (n == restart_at) start8 = 1'b1;
      step();
      start8 = 1'b0;
      if (n == 1) check({tag, "_busy_rise"}, busy8, 1);
      if (valid8) begin
        if (nstrobe >= e) bad_strobe++;
        else if (sel_out8 != chans[nstrobe][2:0] || out8[0] != in8[chans[nstrobe]] ||
                 n != (nstrobe + 1) * 4) bad_strobe++;
        nstrobe++;
      end
      if (n <= e * 4 && sel_out8 != chans[(n - 1) / 4][2:0]) bad_walk++;
      if (done8) done_at = n;
    end
    check({tag, "_strobes"}, nstrobe, e);
    check({tag, "_bad_strobes"}, bad_strobe, 0);
    check({tag, "_bad_walk"}, bad_walk, 0);
    check({tag, "_done_at"}, done_at, e * 4 + 1);
    step();
    check({tag, "_busy_fall"}, {busy8, done8}, 2'b00);
  endtask

  initial begin
    int found;
    int dones;
    int valids;

    vecs[0]  = '{1'b0, 3'd0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 3'd1, 8'h01, 1'b1};
    vecs[2]  = '{1'b0, 3'd2, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 3'd3, 8'h01, 1'b1};
    vecs[4]  = '{1'b0, 3'd4, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 3'd5, 8'h01, 1'b1};
    vecs[6]  = '{1'b0, 3'd6, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 3'd7, 8'h01, 1'b1};
    vecs[8]  = '{1'b1, 3'd0, 8'h11, 1'b1};
    vecs[9]  = '{1'b1, 3'd4, 8'h55, 1'b1};
    vecs[10] = '{1'b1, 3'd6, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 3'd2, 8'h33, 1'b1};
    vecs[12] = '{1'b1, 3'd5, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 3'd3, 8'h44, 1'b1};
    vecs[14] = '{1'b1, 3'd7, 8'h00, 1'b0};

    rst = 1'b1;
    in8 = 8'b10101010; mask8 = 8'h00; mode8 = 1'b0; start8 = 1'b0; sel8 = 3'd5;
    in5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    mask5 = 5'h00; mode5 = 1'b0; start5 = 1'b0; sel5 = 3'd3;
    step();
    step();
    check("reset8", {out8, sel_out8, valid8, busy8, done8}, 7'd0);
    check("reset5", {out5, sel_out5, valid5, busy5, done5}, 14'd0);
    rst = 1'b0;

    // Manual table: one cycle after each select change the new lane appears.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].use5) sel5 = vecs[i].sel;
      else              sel8 = vecs[i].sel;
      step();
      if (vecs[i].use5) begin
        check($sformatf("man5_%0d", i), {out5, sel_out5, valid5},
              {vecs[i].exp_out, vecs[i].sel, vecs[i].exp_valid});
      end else begin
        check($sformatf("man8_%0d", i), {out8, sel_out8, valid8},
              {vecs[i].exp_out[0], vecs[i].sel, vecs[i].exp_valid});
        step();
        check($sformatf("man8_hold_%0d", i), {out8, valid8}, {vecs[i].exp_out[0], 1'b1});
      end
    end

    // Scan mode while idle: outputs hold the last manual sample, valid drops.
    mode8 = 1'b1;
    step();
    check("scan_idle_hold", {out8, sel_out8, valid8, busy8}, {1'b1, 3'd7, 1'b0, 1'b0});

    run_scan("full", 8'hFF, 0);
    run_scan("sparse", 8'b10010010, 0);
    run_scan("empty", 8'h00, 0);
    run_scan("restart", 8'hFF, 6);

    // Abort: dropping mode mid-scan returns to manual with no done pulse.
    mode8 = 1'b1; mask8 = 8'hFF; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (6) step();
    check("abort_busy_before", busy8, 1);
    sel8 = 3'd3;
    mode8 = 1'b0;
    step();
    check("abort_now", {busy8, done8, valid8, sel_out8, out8}, {1'b0, 1'b0, 1'b1, 3'd3, 1'b1});
    dones = 0;
    valids = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (done8) dones++;
      if (valid8) valids++;
    end
    check("abort_no_done", dones, 0);
    check("abort_manual_valid", valids, 40);

    // Reset while the scan sits on channel 3.
    mode8 = 1'b1; mask8 = 8'hFF; start8 = 1'b1;
    step();
    start8 = 1'b0;
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      step();
      if (busy8 && sel_out8 == 3'd3) found = 1;
    end
    check("reset_reach_ch3", found, 1);
    check("reset_pre_out", out8, 1);
    rst = 1'b1;
    step();
    check("reset_mid", {out8, sel_out8, busy8, valid8, done8}, 7'd0);
    rst = 1'b0;
    step();
    check("reset_after_idle", {busy8, valid8, done8}, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
